inst_fetch_buffer: RTL

- Parametrised multi-lane instruction fetch buffer between the instruction memory return path and decode.
- Accepts up to WAYS fetched instructions per cycle and holds them in one shared in-order circular queue of DEPTH entries.
- Presents up to WAYS oldest entries per cycle to decode, each tagged with a rolling program-order ID.
- Supports a single-cycle flush on jump/redirect, with defined push/pop/flush collision rules.

---
 rtl/inst_fetch_buffer_if.sv | 34 +++
 rtl/inst_fetch_buffer.sv | 104 ++++++++++
 2 files changed

// File: rtl/inst_fetch_buffer_if.sv
// Fetch-side and dispatch-side signals of the instruction fetch buffer.
// The buffer uses the slave modport; the fetch source and decode side use master.
interface inst_fetch_buffer_if #(
  parameter int WAYS   = 2,
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int PID_W  = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                     in_valid_i;
  logic [WAYS-1:0]          in_mask_i;
  logic [WAYS*DATA_W-1:0]   in_inst_i;
  logic [WAYS*ADDR_W-1:0]   in_addr_i;
  logic                     ready_o;
  logic                     flush_i;
  logic                     out_ready_i;
  logic [WAYS-1:0]          out_valid_o;
  logic [WAYS*DATA_W-1:0]   out_inst_o;
  logic [WAYS*ADDR_W-1:0]   out_addr_o;
  logic [WAYS*PID_W-1:0]    out_pid_o;
  logic [CNT_W-1:0]         count_o;

  modport slave (
    input  in_valid_i, in_mask_i, in_inst_i, in_addr_i, flush_i, out_ready_i,
    output ready_o, out_valid_o, out_inst_o, out_addr_o, out_pid_o, count_o
  );

  modport master (
    output in_valid_i, in_mask_i, in_inst_i, in_addr_i, flush_i, out_ready_i,
    input  ready_o, out_valid_o, out_inst_o, out_addr_o, out_pid_o, count_o
  );
endinterface

// File: rtl/inst_fetch_buffer.sv
// Multi-lane in-order instruction fetch buffer: up to WAYS pushes and WAYS
// show-ahead pops per cycle over a shared circular queue, with redirect flush.
module inst_fetch_buffer #(
  parameter int WAYS   = 2,
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int PID_W  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  inst_fetch_buffer_if.slave   bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_MASK  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - WAYS);
  localparam logic [CNT_W-1:0] WAYS_C    = CNT_W'(WAYS);

  function automatic logic [CNT_W-1:0] popcount(input logic [WAYS-1:0] m);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int k = 0; k < WAYS; k++) n = n + CNT_W'(m[k]);
    return n;
  endfunction

  function automatic logic [PTR_W-1:0] slot_of(input logic [PTR_W-1:0] base, input int k);
    return (base + PTR_W'(k)) & PTR_MASK;
  endfunction

  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [PID_W-1:0]  pid_mem  [DEPTH];

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [PID_W-1:0]  pid_next;

  logic              ready;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  n_in;
  logic [CNT_W-1:0]  n_out;

  // Acceptance is judged on pre-pop occupancy, so a full beat never waits on decode.
  always_comb begin
    ready = (count <= READY_MAX);
    push  = bus.in_valid_i & ready & ~bus.flush_i & ~reset;
    pop   = bus.out_ready_i & ~bus.flush_i & ~reset;
    n_in  = popcount(bus.in_mask_i);
    n_out = (count < WAYS_C) ? count : WAYS_C;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < WAYS; k++) begin
        if (bus.in_mask_i[k]) begin
          inst_mem[slot_of(wr_ptr, k)] <= bus.in_inst_i[k*DATA_W +: DATA_W];
          addr_mem[slot_of(wr_ptr, k)] <= bus.in_addr_i[k*ADDR_W +: ADDR_W];
          pid_mem[slot_of(wr_ptr, k)]  <= pid_next + PID_W'(k);
        end
      end
    end
  end

  // pid_next survives a flush so program-order IDs stay monotonic across redirects.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      pid_next <= '0;
    end else if (bus.flush_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= (wr_ptr + PTR_W'(n_in)) & PTR_MASK;
        pid_next <= pid_next + PID_W'(n_in);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr + PTR_W'(n_out)) & PTR_MASK;
      end
      count <= count + (push ? n_in : '0) - (pop ? n_out : '0);
    end
  end

  always_comb begin
    bus.ready_o     = ready | reset;
    bus.count_o     = reset ? '0 : count;
    bus.out_valid_o = '0;
    bus.out_inst_o  = '0;
    bus.out_addr_o  = '0;
    bus.out_pid_o   = '0;
    for (int k = 0; k < WAYS; k++) begin
      bus.out_valid_o[k]                = (CNT_W'(k) < count) & ~bus.flush_i & ~reset;
      bus.out_inst_o[k*DATA_W +: DATA_W] = inst_mem[slot_of(rd_ptr, k)];
      bus.out_addr_o[k*ADDR_W +: ADDR_W] = addr_mem[slot_of(rd_ptr, k)];
      bus.out_pid_o[k*PID_W +: PID_W]    = pid_mem[slot_of(rd_ptr, k)];
    end
  end
endmodule
